// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding, bus bit constants, default widths.
package i2c_pkg;

    localparam int unsigned DATA_WD = 8;
    localparam int unsigned ADDR_WD = 7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_DROP
    } state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// Line conditioning for scl/sda: synchroniser, optional stable-sample filter
// (I2C_TGT_GLITCH_FILTER_EN), edge and START/STOP detection.
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_ev,
    output logic stop_ev
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl_sync;
    logic                   w_sda_sync;
    logic                   w_scl_c;
    logic                   w_sda_c;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start_ev;
    logic                   r_stop_ev;

    // Synchroniser chains; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign w_scl_sync = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_sync = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    // Level only follows the input after three equal consecutive samples
    assign w_scl_c = (w_scl_sync == r_scl_hist[0] && r_scl_hist[0] == r_scl_hist[1])
                     ? w_scl_sync : r_scl_filt;
    assign w_sda_c = (w_sda_sync == r_sda_hist[0] && r_sda_hist[0] == r_sda_hist[1])
                     ? w_sda_sync : r_sda_filt;

    // Sample history and held filter level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], w_scl_sync};
            r_sda_hist <= {r_sda_hist[0], w_sda_sync};
            r_scl_filt <= w_scl_c;
            r_sda_filt <= w_sda_c;
        end
    end
`else
    assign w_scl_c = w_scl_sync;
    assign w_sda_c = w_sda_sync;
`endif

    // Edge flop plus registered bus events, all aligned with scl_s/sda_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start_ev <= 1'b0;
            r_stop_ev  <= 1'b0;
        end else begin
            r_scl_d    <= w_scl_c;
            r_sda_d    <= w_sda_c;
            r_scl_rise <= w_scl_c & ~r_scl_d;
            r_scl_fall <= ~w_scl_c & r_scl_d;
            r_start_ev <= r_scl_d & w_scl_c & r_sda_d & ~w_sda_c;
            r_stop_ev  <= r_scl_d & w_scl_c & ~r_sda_d & w_sda_c;
        end
    end

    assign scl_s    = r_scl_d;
    assign sda_s    = r_sda_d;
    assign scl_rise = r_scl_rise;
    assign scl_fall = r_scl_fall;
    assign start_ev = r_start_ev;
    assign stop_ev  = r_stop_ev;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address decode/ACK, LSB-first byte receive and transmit.
// Optional input glitch filter enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int unsigned data_wd     = DATA_WD,
    parameter int unsigned addr_wd     = ADDR_WD,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl,
    inout  wire                sda,
    input  logic [addr_wd-1:0] own_addr,
    input  logic [data_wd-1:0] tx_data,
    output logic [data_wd-1:0] rx_data,
    output logic               rx_valid,
    output logic               rd_req,
    output logic               addr_match,
    output logic               busy
);

    localparam int unsigned CNT_WD = $clog2(data_wd + 1);

    logic               w_scl_s;
    logic               w_sda_s;
    logic               w_scl_rise;
    logic               w_scl_fall;
    logic               w_start_ev;
    logic               w_stop_ev;
    logic               w_bit_rise;
    logic               w_bit_fall;
    logic [data_wd-1:0] w_shift_in;
    logic [addr_wd-1:0] w_addr_rx;

    state_e             r_state;
    logic [CNT_WD-1:0]  r_bit_cnt;
    logic [data_wd-1:0] r_shift;
    logic [addr_wd-1:0] r_own_addr;
    logic               r_rw;
    logic               r_sda_oe;
    logic [data_wd-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_rd_req;
    logic               r_addr_match;
    logic               r_busy;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .scl_s    (w_scl_s),
        .sda_s    (w_sda_s),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start_ev (w_start_ev),
        .stop_ev  (w_stop_ev)
    );

    // Open-drain drive: pull low or release
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    // Edges qualified by the settled scl level
    assign w_bit_rise = w_scl_rise & w_scl_s;
    assign w_bit_fall = w_scl_fall & ~w_scl_s;

    // LSB-first shift: new bit enters at the top, first bit ends at bit 0
    assign w_shift_in = {w_sda_s, r_shift[data_wd-1:1]};

    // After addr_wd shifts the address occupies the top of the shift register
    assign w_addr_rx  = r_shift[data_wd-1 -: addr_wd];

    // Target state machine with registered outputs and sda enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_own_addr   <= '0;
            r_rw         <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rd_req     <= 1'b0;
            r_addr_match <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rd_req   <= 1'b0;

            // tx_data is taken during the cycle rd_req is high
            if (r_rd_req) begin
                r_shift <= tx_data;
            end

            if (w_stop_ev) begin
                r_state      <= ST_IDLE;
                r_bit_cnt    <= '0;
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
                r_busy       <= 1'b0;
            end else if (w_start_ev) begin
                r_state      <= ST_ADDR;
                r_bit_cnt    <= '0;
                r_shift      <= '0;
                r_own_addr   <= own_addr;
                r_sda_oe     <= 1'b0;
                r_addr_match <= 1'b0;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_bit_rise) begin
                            if (r_bit_cnt == CNT_WD'(addr_wd)) begin
                                r_rw      <= w_sda_s;
                                r_bit_cnt <= '0;
                                if (w_addr_rx == r_own_addr) begin
                                    r_state      <= ST_ADDR_ACK;
                                    r_addr_match <= 1'b1;
                                end else begin
                                    r_state <= ST_DROP;
                                end
                            end else begin
                                r_shift   <= w_shift_in;
                                r_bit_cnt <= r_bit_cnt + CNT_WD'(1);
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_bit_rise && r_bit_cnt == '0) begin
                            r_bit_cnt <= CNT_WD'(1);
                            if (r_rw == RW_READ) begin
                                r_rd_req <= 1'b1;
                            end
                        end else if (w_bit_fall) begin
                            if (r_bit_cnt == '0) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_bit_cnt <= '0;
                                if (r_rw == RW_READ) begin
                                    r_sda_oe <= ~r_shift[0];
                                    r_state  <= ST_READ;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_shift  <= '0;
                                    r_state  <= ST_WRITE;
                                end
                            end
                        end
                    end

                    ST_WRITE: begin
                        if (w_bit_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == CNT_WD'(data_wd - 1)) begin
                                r_rx_data  <= w_shift_in;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                                r_state    <= ST_WRITE_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_WD'(1);
                            end
                        end
                    end

                    ST_WRITE_ACK: begin
                        if (w_bit_rise && r_bit_cnt == '0) begin
                            r_bit_cnt <= CNT_WD'(1);
                        end else if (w_bit_fall) begin
                            if (r_bit_cnt == '0) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_state   <= ST_WRITE;
                            end
                        end
                    end

                    ST_READ: begin
                        if (w_bit_rise && r_bit_cnt != CNT_WD'(data_wd)) begin
                            r_shift   <= {1'b0, r_shift[data_wd-1:1]};
                            r_bit_cnt <= r_bit_cnt + CNT_WD'(1);
                        end else if (w_bit_fall) begin
                            if (r_bit_cnt == CNT_WD'(data_wd)) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_state   <= ST_READ_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[0];
                            end
                        end
                    end

                    ST_READ_ACK: begin
                        if (w_bit_rise) begin
                            r_bit_cnt <= '0;
                            if (w_sda_s == I2C_ACK) begin
                                r_rd_req <= 1'b1;
                                r_state  <= ST_READ;
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end
                    end

                    default: begin
                        // IDLE and DROP wait for START/STOP only
                    end
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rd_req     = r_rd_req;
    assign addr_match = r_addr_match;
    assign busy       = r_busy;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Bus-side I2C target (slave) that sits directly downstream of the team's I2C controller on the same scl/sda wires.
- Oversamples scl/sda on the system clock and detects START/STOP.
- Decodes a 7-bit address plus R/W bit and ACKs on address match.
- Write transfers: receives bytes and presents them to local logic.
- Read transfers: shifts out bytes supplied by local logic.
- Bit order is LSB first, both directions, so it matches the controller. The R/W bit follows the 7 address bits; 1 = read.

Parameters:
- data_wd, 8, data byte width in bits.
- addr_wd, 7, target address width in bits.
- SYNC_STAGES, 2, synchroniser depth on scl/sda inputs (≥2).

Ports:
- clk  input  1  system clock; must be ≥8× scl frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  I2C clock from the controller.
- sda  inout  1  I2C data; driven only as 0 or Z (open drain).
- own_addr  input  addr_wd  this target's address; sampled at each START.
- tx_data  input  data_wd  byte to return on a read; captured on the rd_req cycle.
- rx_data  output  data_wd  last byte received in a write.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rd_req  output  1  one-clk pulse; tx_data is captured in the same cycle.
- addr_match  output  1  high from the matched address ACK until STOP or START.
- busy  output  1  high between START and STOP, whether or not the address matches.

Behaviour:
- Reset values: every output is 0; sda is released (Z); state is IDLE; shift register and bit counter are 0.
- Input conditioning:
  - scl and sda pass through SYNC_STAGES flops, then one more flop for edge detection.
  - Edge events are therefore seen SYNC_STAGES+1 clk after the pin changes.
- Bus events, evaluated on synced signals:
  - START = sda falls while scl is high.
  - STOP = sda rises while scl is high.
  - Data is sampled on the scl rise event; sda drive changes only on the scl fall event.
- Priority: STOP > START > bit event. A START in any state (repeated START) goes to ADDR, clears bit_cnt and drops addr_match.
- State machine:
  - IDLE: START -> ADDR; busy=1.
  - ADDR: shift 8 bits (7 address LSB first, then R/W), one per scl rise. After the 8th, compare to own_addr.
    - Match -> ADDR_ACK.
    - Mismatch -> DROP.
  - ADDR_ACK: drive sda=0 from the next scl fall until the following scl fall; assert addr_match.
    - R/W=0 -> WRITE.
    - R/W=1 -> pulse rd_req and load tx_data into the shift register, then READ.
  - WRITE: shift data_wd bits, LSB first. On the last bit, rx_data <= shifted byte and rx_valid pulses, then WRITE_ACK.
  - WRITE_ACK: drive the ACK as in ADDR_ACK, then return to WRITE for the next byte.
  - READ: on each scl fall, drive sda=0 when the current bit is 0, else Z. After data_wd bits, release sda -> READ_ACK.
  - READ_ACK: sample the controller's bit on scl rise.
    - 0 (ACK) -> rd_req pulse, reload tx_data, READ.
    - 1 (NACK) -> DROP.
  - DROP: sda released and ignore all bits. Leave only on STOP or START.
- STOP in any state -> IDLE; busy=0, addr_match=0, sda released. A byte that is only partly received is discarded, with no rx_valid.
- Counter: bit_cnt is clog2(data_wd+1) bits. It counts scl rises within a byte and clears on entry to each byte or ACK phase. It never wraps past data_wd.
- Simultaneous events:
  - rx_valid and rd_req can never both be asserted.
  - A START coincident with the last address bit wins; no compare is made.
- Reset mid-transfer releases sda immediately, which is asynchronous via the output-enable flop.

Optional Feature:
- Macro: I2C_TGT_GLITCH_FILTER_EN.
- Defined: after the synchroniser, scl and sda each feed a 3-sample stable filter. The filtered value changes only after 3 consecutive equal samples. This adds 2 clk of event latency and rejects pulses ≤2 clk wide.
- Undefined: the synchroniser output is used directly. Single-clk glitches are seen as edges.

Decomposition:
- Shared package i2c_pkg:
  - state_e enum for target states.
  - I2C_ACK=1'b0 and I2C_NACK=1'b1 constants.
  - RW_READ=1'b1 constant.
  - Default widths (DATA_WD=8, ADDR_WD=7), also reusable by the controller.
- One natural sub-module: i2c_line_cond. It holds the synchroniser, optional glitch filter and edge/START/STOP detector, and outputs scl_s, sda_s, scl_rise, scl_fall, start_ev and stop_ev. It is instantiated once, covering both lines.

Test Plan:
- own_addr=7'h2A; write addr 7'h2A, R/W=0, byte 8'hC5, STOP -> ACK low on both 9th clocks; rx_data=8'hC5 with one rx_valid; busy falls after STOP.
- own_addr=7'h2A; read addr 7'h2A with tx_data=8'h96, controller NACKs -> sda carries 0,1,1,0,1,0,0,1 (LSB first); rd_req pulses once; state DROP, then IDLE on STOP.
- Address 7'h15 vs own_addr 7'h2A -> sda never driven low; addr_match=0; no rx_valid or rd_req; busy still high until STOP.
- Write 2 bytes 8'h01, 8'hFF, repeated START, read one byte -> two rx_valid pulses in order; addr_match drops at the repeated START then re-asserts; one rd_req.
- Assert rst_n=0 while the target is driving ACK -> sda is Z within the same cycle; all outputs are 0; the next full transaction completes correctly.
- With I2C_TGT_GLITCH_FILTER_EN, inject a 1-clk low glitch on sda while scl is high -> no START or STOP detected; without the macro, a START is detected.
